// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer: FSM state encoding,
// default sync marker and the game opcodes carried in CMD bytes.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ARG  = 3'd2,
    CSUM = 3'd3,
    HOLD = 3'd4
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam logic [7:0] CMD_DIR   = 8'h01;
  localparam logic [7:0] CMD_START = 8'h02;
  localparam logic [7:0] CMD_PAUSE = 8'h03;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Loadable up-counter with clear/enable; expired is high once the count reaches
// LIMIT-1, and the count holds there until cleared or loaded.
module uart_cmd_timeout #(
  parameter  int LIMIT = 50000,
  localparam int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  assign expired = (count_q == W'(LIMIT - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (load)                count_d = load_val;
    else if (clr)            count_d = '0;
    else if (en && !expired) count_d = count_q + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/uart_cmd_controller.sv
// Frames UART bytes (SYNC, CMD, ARG, CSUM) into validated game commands.
// Define UART_CMD_STATS_EN to build the saturating good/bad frame counters.
module uart_cmd_controller
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [7:0]       cmd_code,
  output logic [7:0]       cmd_arg,
  output logic             csum_err,
  output logic             timeout_err,
  output logic             overrun_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e     state_q, state_d;
  logic [7:0] cmd_r_q, cmd_r_d, arg_r_q, arg_r_d;
  logic [7:0] code_q, code_d, carg_q, carg_d;
  logic       csum_err_q, csum_err_d;
  logic       timeout_err_q, timeout_err_d;
  logic       overrun_err_q, overrun_err_d;
  logic [7:0] csum_exp;
  logic       in_frame, expired, handshake;

  assign csum_exp  = cmd_r_q + arg_r_q;
  assign in_frame  = (state_q == CMD) || (state_q == ARG) || (state_q == CSUM);
  assign handshake = (state_q == HOLD) && cmd_ready;

  uart_cmd_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val ({TMR_W{1'b0}}),
    .clr      (rx_valid),
    .en       (in_frame),
    .expired  (expired)
  );

  always_comb begin
    state_d       = state_q;
    cmd_r_d       = cmd_r_q;
    arg_r_d       = arg_r_q;
    code_d        = code_q;
    carg_d        = carg_q;
    csum_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    overrun_err_d = 1'b0;
    unique case (state_q)
      IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = CMD;
      CMD: begin
        if (rx_valid) begin
          cmd_r_d = rx_data;
          state_d = ARG;
        end else if (expired) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      ARG: begin
        if (rx_valid) begin
          arg_r_d = rx_data;
          state_d = CSUM;
        end else if (expired) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_exp) begin
            code_d  = cmd_r_q;
            carg_d  = arg_r_q;
            state_d = HOLD;
          end else begin
            csum_err_d = 1'b1;
            state_d    = IDLE;
          end
        end else if (expired) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      HOLD: begin
        // A byte landing on the handshake cycle is judged as if already back in IDLE.
        if (cmd_ready) begin
          state_d = (rx_valid && rx_data == SYNC_BYTE) ? CMD : IDLE;
        end else if (rx_valid) begin
          overrun_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_r_q       <= '0;
      arg_r_q       <= '0;
      code_q        <= '0;
      carg_q        <= '0;
      csum_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_r_q       <= cmd_r_d;
      arg_r_q       <= arg_r_d;
      code_q        <= code_d;
      carg_q        <= carg_d;
      csum_err_q    <= csum_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign cmd_valid   = (state_q == HOLD);
  assign cmd_code    = code_q;
  assign cmd_arg     = carg_q;
  assign csum_err    = csum_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

`ifdef UART_CMD_STATS_EN
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic             bad_evt;

  assign bad_evt = csum_err_d || timeout_err_d || overrun_err_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (handshake && good_cnt_q != '1) good_cnt_d = good_cnt_q + CNT_W'(1);
    if (bad_evt && bad_cnt_q != '1)    bad_cnt_d  = bad_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign good_cnt = good_cnt_q;
  assign bad_cnt  = bad_cnt_q;
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Directed bench for uart_cmd_controller with a 100-cycle inter-byte timeout;
// counter expectations follow UART_CMD_STATS_EN.
module tb_uart_cmd_controller;

  localparam int         TMO = 100;
  localparam int         GAP = 10;
  localparam logic [7:0] SYN = 8'hA5;
`ifdef UART_CMD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [7:0] cmd_code, cmd_arg;
  logic       csum_err, timeout_err, overrun_err;
  logic [7:0] good_cnt, bad_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int csum_seen = 0, tmo_seen = 0, ovr_seen = 0, hs_seen = 0;

  uart_cmd_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_arg     (cmd_arg),
    .csum_err    (csum_err),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  always #5 clk = ~clk;

  // Pre-edge values are sampled here, so each visible cycle is counted once.
  always @(posedge clk) begin
    if (rst_n) begin
      csum_seen += int'(csum_err);
      tmo_seen  += int'(timeout_err);
      ovr_seen  += int'(overrun_err);
      hs_seen   += int'(cmd_valid && cmd_ready);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before 300000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Returns on the negedge right after the checksum byte is sampled.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
    send_byte(SYN); idle(GAP);
    send_byte(c);   idle(GAP);
    send_byte(a);   idle(GAP);
    send_byte(s);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; cmd_ready = 1'b0;
    idle(3);
    check("rst_valid", cmd_valid, 0);
    check("rst_code", cmd_code, 0);
    check("rst_errs", {csum_err, timeout_err, overrun_err}, 0);
    check("rst_cnts", {good_cnt, bad_cnt}, 0);
    rst_n = 1'b1;
    idle(2);

    // Good frame, consumer ready: one-cycle cmd_valid.
    cmd_ready = 1'b1;
    send_frame(8'h01, 8'h02, 8'h03);
    check("t1_valid", cmd_valid, 1);
    check("t1_code", cmd_code, 8'h01);
    check("t1_arg", cmd_arg, 8'h02);
    idle(1);
    check("t1_valid_drop", cmd_valid, 0);
    idle(GAP);
    check("t1_hs", hs_seen, 1);
    check("t1_good", good_cnt, STATS ? 1 : 0);

    // Bad checksum.
    send_frame(8'h01, 8'h02, 8'h04);
    check("t2_csum", csum_err, 1);
    check("t2_valid", cmd_valid, 0);
    idle(1);
    check("t2_csum_drop", csum_err, 0);
    idle(GAP);
    check("t2_csum_seen", csum_seen, 1);
    check("t2_bad", bad_cnt, STATS ? 1 : 0);

    // Inter-byte timeout: pulse exactly TMO cycles after the 03 strobe.
    send_byte(SYN); idle(GAP);
    send_byte(8'h03);
    idle(TMO - 1);
    check("t3_tmo_early", timeout_err, 0);
    idle(1);
    check("t3_tmo", timeout_err, 1);
    idle(1);
    check("t3_tmo_drop", timeout_err, 0);
    idle(GAP);
    send_frame(8'h01, 8'h05, 8'h06);
    check("t3_after_code", {cmd_valid, cmd_code, cmd_arg}, {1'b1, 8'h01, 8'h05});
    idle(GAP);
    check("t3_hs", hs_seen, 2);
    check("t3_tmo_seen", tmo_seen, 1);
    check("t3_cnts", {good_cnt, bad_cnt}, STATS ? {8'd2, 8'd2} : 16'd0);

    // Overrun while holding a command.
    cmd_ready = 1'b0;
    send_frame(8'h02, 8'h00, 8'h02);
    check("t4_hold", {cmd_valid, cmd_code, cmd_arg}, {1'b1, 8'h02, 8'h00});
    idle(GAP);
    send_byte(8'h55);
    check("t4_ovr", overrun_err, 1);
    check("t4_keep", {cmd_valid, cmd_code, cmd_arg}, {1'b1, 8'h02, 8'h00});
    idle(GAP);
    cmd_ready = 1'b1;
    idle(1);
    check("t4_release", cmd_valid, 0);
    idle(GAP);
    check("t4_hs", hs_seen, 3);
    check("t4_ovr_seen", ovr_seen, 1);
    check("t4_cnts", {good_cnt, bad_cnt}, STATS ? {8'd3, 8'd3} : 16'd0);

    // SYNC arriving on the handshake cycle starts the next frame.
    cmd_ready = 1'b0;
    send_frame(8'h03, 8'h07, 8'h0A);
    check("t5_hold", {cmd_valid, cmd_code, cmd_arg}, {1'b1, 8'h03, 8'h07});
    idle(3);
    @(negedge clk);
    rx_data = SYN; rx_valid = 1'b1; cmd_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; cmd_ready = 1'b0;
    check("t5_no_ovr", overrun_err, 0);
    check("t5_valid_drop", cmd_valid, 0);
    idle(GAP);
    send_byte(8'h01); idle(GAP);
    send_byte(8'h01); idle(GAP);
    send_byte(8'h02);
    check("t5_second", {cmd_valid, cmd_code, cmd_arg}, {1'b1, 8'h01, 8'h01});
    cmd_ready = 1'b1;
    idle(GAP);
    check("t5_hs", hs_seen, 5);
    check("t5_ovr_seen", ovr_seen, 1);
    check("t5_good", good_cnt, STATS ? 5 : 0);

    // Stray bytes in IDLE are ignored silently.
    send_byte(8'h00); idle(GAP);
    send_byte(8'hFF); idle(GAP);
    send_byte(8'h5A); idle(GAP);
    check("t6_quiet", {csum_seen, tmo_seen, ovr_seen}, {32'd1, 32'd1, 32'd1});
    check("t6_valid", cmd_valid, 0);
    check("t6_bad", bad_cnt, STATS ? 3 : 0);

    // Reset mid-frame abandons it without a pulse.
    send_byte(SYN); idle(GAP);
    send_byte(8'h01); idle(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {cmd_valid, csum_err, timeout_err, overrun_err}, 0);
    check("t6_rst_cnts", {good_cnt, bad_cnt, cmd_code, cmd_arg}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_frame(8'h01, 8'h02, 8'h03);
    check("t6_frame", {cmd_valid, cmd_code, cmd_arg}, {1'b1, 8'h01, 8'h02});
    idle(GAP);
    check("t6_errs", {csum_seen, tmo_seen, ovr_seen}, {32'd1, 32'd1, 32'd1});
    check("t6_cnts", {good_cnt, bad_cnt}, STATS ? {8'd1, 8'd0} : 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
